writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage of the CPU, directly upstream of the register file.
- Accepts one instruction at a time from the memory stage over a valid/ready handshake.
- For loads, waits for the data-bus response, then aligns and sign/zero-extends the loaded data.
- Drives the register-file write port (wa3/write_enable/wd3) and exports forwarding/interlock information to decode, because the register file returns pre-write values in the same cycle.

Parameters:
- RESET_PC, 32'hbfc0_0000: reset value of the committed-PC register.
- LDT_W, 3: width of the load-type code.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- m_valid  in  1  memory stage presents an instruction.
- m_ready  out  1  stage can accept this cycle.
- m_wa  in  5  destination register.
- m_wen  in  1  instruction writes a register.
- m_is_load  in  1  instruction is a load.
- m_ldt  in  LDT_W  load type: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW; other codes are treated as LW.
- m_addr_lo  in  2  low bits of the load address.
- m_result  in  32  ALU result for non-loads.
- m_pc  in  32  instruction PC.
- d_data_ok  in  1  data-bus read response valid.
- d_data  in  32  raw data-bus read word.
- wa3  out  5  register-file write address.
- write_enable  out  1  register-file write strobe.
- wd3  out  32  register-file write data.
- fwd_valid  out  1  wa3/wd3 hold a value decode may bypass.
- fwd_busy  out  1  load in flight to fwd_wa; decode must stall on a match.
- fwd_wa  out  5  destination of the held instruction.
- wb_pc  out  32  PC of the instruction in this stage.

Behaviour:
- States: EMPTY, WAIT_DATA, COMMIT. Reset state is EMPTY.
- Reset values: wa3=0, wd3=0, write_enable=0, fwd_valid=0, fwd_busy=0, fwd_wa=0, wb_pc=RESET_PC.
- Asserting resetn low mid-load abandons the load immediately; no write ever occurs for it.
- m_ready = (state==EMPTY) || (state==COMMIT). COMMIT lasts exactly one cycle, so back-to-back accepts are allowed.
- A handshake occurs when m_valid && m_ready. On a handshake, the stage captures m_wa, m_wen, m_pc, m_ldt and m_addr_lo.
- Accept of a non-load → COMMIT next cycle with wd3=m_result.
- Accept of a load → WAIT_DATA.
- d_data_ok is sampled only in WAIT_DATA; it is ignored in every other state.
- WAIT_DATA with d_data_ok → COMMIT next cycle with wd3 = extended data.
- WAIT_DATA without d_data_ok: stay in WAIT_DATA indefinitely.
- COMMIT with no accept → EMPTY.
- Data extension:
  - LB/LBU select byte m_addr_lo.
  - LH/LHU select half m_addr_lo[1]; m_addr_lo[0] is ignored.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Write strobe: write_enable=1 only in COMMIT, and only when the captured wen=1 and wa3≠0. A destination of register 0 never strobes.
- Latency: non-load write strobe occurs 1 cycle after accept; load write strobe occurs 1 cycle after d_data_ok.
- Forwarding outputs:
  - fwd_valid = write_enable.
  - fwd_busy = (state==WAIT_DATA) && wen && wa≠0.
  - fwd_wa = captured wa in WAIT_DATA/COMMIT, else 0.
- wb_pc updates on every accept and holds otherwise.
- Outputs are registered. wd3/wa3 hold their last value in EMPTY; only write_enable gates the register write.

Optional Feature:
- Macro WB_LOAD_MISALIGN_CHECK_EN.
- When defined: adds output ld_misalign (1 bit, reset 0). It pulses for one cycle in COMMIT when a completed LH/LHU has m_addr_lo[0]=1, or a completed LW has m_addr_lo≠0. In that cycle write_enable is forced to 0.
- When undefined: port absent; misaligned loads write the data selected per the rules above.

Test Plan:
- Non-load: accept ADDU with m_wa=5, m_result=32'h1234_5678 → next cycle write_enable=1, wa3=5, wd3=32'h1234_5678, fwd_valid=1; following cycle write_enable=0.
- Load wait: accept LB with m_wa=8, m_addr_lo=2; hold d_data_ok=0 for 3 cycles → m_ready=0 and fwd_busy=1, fwd_wa=8 throughout. Then d_data_ok=1, d_data=32'h0080_0000 → next cycle wd3=32'hffff_ff80, write_enable=1.
- Extension: LHU with m_addr_lo=2, d_data=32'h8001_7fff → wd3=32'h0000_8001. LH at addr_lo=0 on the same word → wd3=32'h0000_7fff.
- Register 0: accept a non-load with m_wa=0, m_wen=1 → COMMIT occurs (wb_pc updates) but write_enable stays 0.
- Back-to-back: non-loads to r3 then r4 on consecutive cycles → m_ready held 1; write strobes on two consecutive cycles in order r3, r4.
- Reset mid-load: resetn low while in WAIT_DATA, then d_data_ok=1 after release → no write_enable, state EMPTY, m_ready=1.

Source files
------------

// File: rtl/writeback_stage_if.sv
// -----------------------------------------------------------------------------
// writeback_stage_if
//   Groups the memory-stage -> writeback handshake and the data-bus read
//   response that feeds the writeback stage.
//
//   Signals:
//     m_valid    memory stage presents an instruction
//     m_ready    writeback stage can accept this cycle
//     m_wa       destination register
//     m_wen      instruction writes a register
//     m_is_load  instruction is a load
//     m_ldt      load type (0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, others = LW)
//     m_addr_lo  low two bits of the load address
//     m_result   ALU result for non-loads
//     m_pc       instruction PC
//     d_data_ok  data-bus read response valid
//     d_data     raw data-bus read word
//
//   Modports:
//     master  upstream side (memory stage / data bus) driving the request
//     slave   writeback stage consuming it
// -----------------------------------------------------------------------------
interface writeback_stage_if #(
    parameter int LDT_W = 3
) ();
    logic              m_valid;
    logic              m_ready;
    logic [4:0]        m_wa;
    logic              m_wen;
    logic              m_is_load;
    logic [LDT_W-1:0]  m_ldt;
    logic [1:0]        m_addr_lo;
    logic [31:0]       m_result;
    logic [31:0]       m_pc;
    logic              d_data_ok;
    logic [31:0]       d_data;

    modport master (
        output m_valid, m_wa, m_wen, m_is_load, m_ldt, m_addr_lo,
               m_result, m_pc, d_data_ok, d_data,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_wa, m_wen, m_is_load, m_ldt, m_addr_lo,
               m_result, m_pc, d_data_ok, d_data,
        output m_ready
    );
endinterface

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//   Final CPU pipeline stage. Accepts one instruction at a time from the
//   memory stage, waits for the data-bus response on loads, aligns and
//   extends load data, then drives the register-file write port. It also
//   exports bypass/interlock information to decode, since the register file
//   returns pre-write values in the cycle of the write.
//
//   Ports:
//     clk           clock, rising edge
//     resetn        asynchronous active-low reset
//     m             writeback_stage_if.slave (handshake + data-bus response)
//     wa3           register-file write address
//     write_enable  register-file write strobe
//     wd3           register-file write data
//     fwd_valid     wa3/wd3 hold a bypassable value
//     fwd_busy      load in flight to fwd_wa; decode stalls on a match
//     fwd_wa        destination of the held instruction
//     wb_pc         PC of the instruction in this stage
//     ld_misalign   (only with WB_LOAD_MISALIGN_CHECK_EN) one-cycle pulse on
//                   a completed misaligned LH/LHU/LW; its write is suppressed
//
//   Optional feature macro: WB_LOAD_MISALIGN_CHECK_EN
// -----------------------------------------------------------------------------
module writeback_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
    parameter int          LDT_W    = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    writeback_stage_if.slave      m,
    output logic [4:0]            wa3,
    output logic                  write_enable,
    output logic [31:0]           wd3,
    output logic                  fwd_valid,
    output logic                  fwd_busy,
    output logic [4:0]            fwd_wa,
    output logic [31:0]           wb_pc
`ifdef WB_LOAD_MISALIGN_CHECK_EN
    ,
    output logic                  ld_misalign
`endif
);

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        WAIT_DATA = 2'd1,
        COMMIT    = 2'd2
    } state_t;

    localparam logic [LDT_W-1:0] LDT_LB  = LDT_W'(0);
    localparam logic [LDT_W-1:0] LDT_LBU = LDT_W'(1);
    localparam logic [LDT_W-1:0] LDT_LH  = LDT_W'(2);
    localparam logic [LDT_W-1:0] LDT_LHU = LDT_W'(3);

    state_t            state_reg;
    logic [4:0]        wa_reg;
    logic              wen_reg;
    logic [LDT_W-1:0]  ldt_reg;
    logic [1:0]        addr_lo_reg;

    logic              accept;
    logic [7:0]        byte_lane [4];
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_data;
    logic              load_we;

    // m_ready depends only on the state register, so it never combinationally
    // depends on m_valid.
    assign m.m_ready = (state_reg == EMPTY) || (state_reg == COMMIT);
    assign accept    = m.m_valid && m.m_ready;

    // Byte lanes of the raw bus word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = m.d_data[8*gi +: 8];
        end
    endgenerate

    // Alignment/extension from the captured load type and address; the raw
    // word is only meaningful in WAIT_DATA when d_data_ok is high.
    always_comb begin
        byte_sel = byte_lane[addr_lo_reg];
        half_sel = addr_lo_reg[1] ? m.d_data[31:16] : m.d_data[15:0];
        case (ldt_reg)
            LDT_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            LDT_LBU: load_data = {24'd0, byte_sel};
            LDT_LH:  load_data = {{16{half_sel[15]}}, half_sel};
            LDT_LHU: load_data = {16'd0, half_sel};
            default: load_data = m.d_data;
        endcase
    end

`ifdef WB_LOAD_MISALIGN_CHECK_EN
    logic misalign_now;
    always_comb begin
        case (ldt_reg)
            LDT_LB, LDT_LBU: misalign_now = 1'b0;
            LDT_LH, LDT_LHU: misalign_now = addr_lo_reg[0];
            default:         misalign_now = (addr_lo_reg != 2'd0);
        endcase
    end
    assign load_we = wen_reg && (wa_reg != 5'd0) && !misalign_now;
`else
    assign load_we = wen_reg && (wa_reg != 5'd0);
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= EMPTY;
            wa_reg       <= 5'd0;
            wen_reg      <= 1'b0;
            ldt_reg      <= '0;
            addr_lo_reg  <= 2'd0;
            wa3          <= 5'd0;
            wd3          <= 32'd0;
            write_enable <= 1'b0;
            fwd_valid    <= 1'b0;
            fwd_busy     <= 1'b0;
            fwd_wa       <= 5'd0;
            wb_pc        <= RESET_PC;
`ifdef WB_LOAD_MISALIGN_CHECK_EN
            ld_misalign  <= 1'b0;
`endif
        end else begin
`ifdef WB_LOAD_MISALIGN_CHECK_EN
            ld_misalign <= 1'b0;
`endif
            if (accept) begin
                // Accept is possible from EMPTY or COMMIT; either way the new
                // instruction replaces whatever was held.
                wa_reg      <= m.m_wa;
                wen_reg     <= m.m_wen;
                ldt_reg     <= m.m_ldt;
                addr_lo_reg <= m.m_addr_lo;
                wb_pc       <= m.m_pc;
                fwd_wa      <= m.m_wa;
                if (m.m_is_load) begin
                    state_reg    <= WAIT_DATA;
                    write_enable <= 1'b0;
                    fwd_valid    <= 1'b0;
                    fwd_busy     <= m.m_wen && (m.m_wa != 5'd0);
                end else begin
                    state_reg    <= COMMIT;
                    wa3          <= m.m_wa;
                    wd3          <= m.m_result;
                    write_enable <= m.m_wen && (m.m_wa != 5'd0);
                    fwd_valid    <= m.m_wen && (m.m_wa != 5'd0);
                    fwd_busy     <= 1'b0;
                end
            end else begin
                case (state_reg)
                    WAIT_DATA: begin
                        if (m.d_data_ok) begin
                            state_reg    <= COMMIT;
                            wa3          <= wa_reg;
                            wd3          <= load_data;
                            write_enable <= load_we;
                            fwd_valid    <= load_we;
                            fwd_busy     <= 1'b0;
`ifdef WB_LOAD_MISALIGN_CHECK_EN
                            ld_misalign  <= misalign_now;
`endif
                        end
                    end
                    COMMIT: begin
                        // wa3/wd3 keep their last value; only the strobe drops.
                        state_reg    <= EMPTY;
                        write_enable <= 1'b0;
                        fwd_valid    <= 1'b0;
                        fwd_busy     <= 1'b0;
                        fwd_wa       <= 5'd0;
                    end
                    default: begin
                        state_reg <= EMPTY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
//   Directed testbench for writeback_stage. Inputs are driven 1 time unit
//   after each rising edge and outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_writeback_stage;

    localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

    logic        clk;
    logic        resetn;
    logic [4:0]  wa3;
    logic        write_enable;
    logic [31:0] wd3;
    logic        fwd_valid;
    logic        fwd_busy;
    logic [4:0]  fwd_wa;
    logic [31:0] wb_pc;
`ifdef WB_LOAD_MISALIGN_CHECK_EN
    logic        ld_misalign;
`endif

    int checks   = 0;
    int failures = 0;

    writeback_stage_if #(.LDT_W(3)) bus ();

    writeback_stage #(
        .RESET_PC (RESET_PC),
        .LDT_W    (3)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .m            (bus),
        .wa3          (wa3),
        .write_enable (write_enable),
        .wd3          (wd3),
        .fwd_valid    (fwd_valid),
        .fwd_busy     (fwd_busy),
        .fwd_wa       (fwd_wa),
        .wb_pc        (wb_pc)
`ifdef WB_LOAD_MISALIGN_CHECK_EN
        ,
        .ld_misalign  (ld_misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-24s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic present(input logic is_load, input logic [4:0] wa, input logic wen,
                           input logic [2:0] ldt, input logic [1:0] alo,
                           input logic [31:0] result, input logic [31:0] pc);
        bus.m_valid   = 1'b1;
        bus.m_is_load = is_load;
        bus.m_wa      = wa;
        bus.m_wen     = wen;
        bus.m_ldt     = ldt;
        bus.m_addr_lo = alo;
        bus.m_result  = result;
        bus.m_pc      = pc;
    endtask

    // Accept a load, respond one cycle later and check the extended data.
    task automatic load_check(input string tag, input logic [4:0] wa, input logic [2:0] ldt,
                              input logic [1:0] alo, input logic [31:0] data,
                              input logic [31:0] exp_wd3);
        present(1'b1, wa, 1'b1, ldt, alo, 32'h0, 32'h300);
        tick();
        bus.m_valid   = 1'b0;
        bus.d_data_ok = 1'b1;
        bus.d_data    = data;
        tick();
        bus.d_data_ok = 1'b0;
        chk({tag, "_wd3"}, wd3, exp_wd3);
        chk({tag, "_we"}, {31'd0, write_enable}, 32'd1);
        tick();
    endtask

    initial begin
        resetn        = 1'b0;
        bus.m_valid   = 1'b0;
        bus.m_is_load = 1'b0;
        bus.m_wa      = 5'd0;
        bus.m_wen     = 1'b0;
        bus.m_ldt     = 3'd0;
        bus.m_addr_lo = 2'd0;
        bus.m_result  = 32'd0;
        bus.m_pc      = 32'd0;
        bus.d_data_ok = 1'b0;
        bus.d_data    = 32'd0;

        // ---- reset state
        tick();
        tick();
        chk("rst_wa3", {27'd0, wa3}, 32'd0);
        chk("rst_wd3", wd3, 32'd0);
        chk("rst_we", {31'd0, write_enable}, 32'd0);
        chk("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        chk("rst_fwd_busy", {31'd0, fwd_busy}, 32'd0);
        chk("rst_fwd_wa", {27'd0, fwd_wa}, 32'd0);
        chk("rst_wb_pc", wb_pc, RESET_PC);
        chk("rst_m_ready", {31'd0, bus.m_ready}, 32'd1);
        resetn = 1'b1;
        tick();

        // ---- d_data_ok is ignored while EMPTY
        bus.d_data_ok = 1'b1;
        bus.d_data    = 32'hdead_beef;
        tick();
        bus.d_data_ok = 1'b0;
        chk("empty_ok_we", {31'd0, write_enable}, 32'd0);
        chk("empty_ok_ready", {31'd0, bus.m_ready}, 32'd1);

        // ---- non-load ADDU to r5
        present(1'b0, 5'd5, 1'b1, 3'd0, 2'd0, 32'h1234_5678, 32'h0000_0100);
        tick();
        bus.m_valid = 1'b0;
        chk("addu_we", {31'd0, write_enable}, 32'd1);
        chk("addu_wa3", {27'd0, wa3}, 32'd5);
        chk("addu_wd3", wd3, 32'h1234_5678);
        chk("addu_fwd_valid", {31'd0, fwd_valid}, 32'd1);
        chk("addu_fwd_wa", {27'd0, fwd_wa}, 32'd5);
        chk("addu_wb_pc", wb_pc, 32'h0000_0100);
        tick();
        chk("addu_we_drop", {31'd0, write_enable}, 32'd0);
        chk("addu_wd3_hold", wd3, 32'h1234_5678);
        chk("addu_fwd_wa_clr", {27'd0, fwd_wa}, 32'd0);

        // ---- LB r8, addr_lo=2, three wait cycles
        present(1'b1, 5'd8, 1'b1, 3'd0, 2'd2, 32'h0, 32'h0000_0104);
        tick();
        bus.m_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("lb_wait_ready", {31'd0, bus.m_ready}, 32'd0);
            chk("lb_wait_busy", {31'd0, fwd_busy}, 32'd1);
            chk("lb_wait_fwd_wa", {27'd0, fwd_wa}, 32'd8);
            chk("lb_wait_we", {31'd0, write_enable}, 32'd0);
            tick();
        end
        bus.d_data_ok = 1'b1;
        bus.d_data    = 32'h0080_0000;
        tick();
        bus.d_data_ok = 1'b0;
        chk("lb_wd3", wd3, 32'hffff_ff80);
        chk("lb_we", {31'd0, write_enable}, 32'd1);
        chk("lb_wa3", {27'd0, wa3}, 32'd8);
        chk("lb_busy_clr", {31'd0, fwd_busy}, 32'd0);
        chk("lb_wb_pc", wb_pc, 32'h0000_0104);
        tick();

        // ---- extension cases
        load_check("lhu_a2", 5'd9, 3'd3, 2'd2, 32'h8001_7fff, 32'h0000_8001);
        load_check("lh_a0", 5'd9, 3'd2, 2'd0, 32'h8001_7fff, 32'h0000_7fff);
        load_check("lh_a2", 5'd9, 3'd2, 2'd2, 32'h8001_7fff, 32'hffff_8001);
        load_check("lbu_a3", 5'd10, 3'd1, 2'd3, 32'h80ff_0000, 32'h0000_0080);
        load_check("lb_a1", 5'd10, 3'd0, 2'd1, 32'h0000_7f00, 32'h0000_007f);
        load_check("lw", 5'd11, 3'd4, 2'd0, 32'hcafe_f00d, 32'hcafe_f00d);
        load_check("ldt7_lw", 5'd11, 3'd7, 2'd0, 32'h1357_9bdf, 32'h1357_9bdf);

        // ---- register 0 never strobes
        present(1'b0, 5'd0, 1'b1, 3'd0, 2'd0, 32'haaaa_5555, 32'h0000_0200);
        tick();
        bus.m_valid = 1'b0;
        chk("r0_wb_pc", wb_pc, 32'h0000_0200);
        chk("r0_we", {31'd0, write_enable}, 32'd0);
        chk("r0_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        tick();

        // ---- wen=0 does not strobe
        present(1'b0, 5'd7, 1'b0, 3'd0, 2'd0, 32'h0000_0077, 32'h0000_0204);
        tick();
        bus.m_valid = 1'b0;
        chk("nowen_we", {31'd0, write_enable}, 32'd0);
        tick();

        // ---- back-to-back non-loads r3, r4
        present(1'b0, 5'd3, 1'b1, 3'd0, 2'd0, 32'h0000_0033, 32'h0000_0300);
        tick();
        present(1'b0, 5'd4, 1'b1, 3'd0, 2'd0, 32'h0000_0044, 32'h0000_0304);
        chk("b2b_ready", {31'd0, bus.m_ready}, 32'd1);
        chk("b2b_we1", {31'd0, write_enable}, 32'd1);
        chk("b2b_wa3_1", {27'd0, wa3}, 32'd3);
        chk("b2b_wd3_1", wd3, 32'h0000_0033);
        tick();
        bus.m_valid = 1'b0;
        chk("b2b_we2", {31'd0, write_enable}, 32'd1);
        chk("b2b_wa3_2", {27'd0, wa3}, 32'd4);
        chk("b2b_wd3_2", wd3, 32'h0000_0044);
        chk("b2b_wb_pc", wb_pc, 32'h0000_0304);
        tick();
        chk("b2b_we_drop", {31'd0, write_enable}, 32'd0);

`ifdef WB_LOAD_MISALIGN_CHECK_EN
        // ---- misaligned LH suppresses the write
        present(1'b1, 5'd12, 1'b1, 3'd2, 2'd1, 32'h0, 32'h0000_0400);
        tick();
        bus.m_valid   = 1'b0;
        bus.d_data_ok = 1'b1;
        bus.d_data    = 32'h1111_2222;
        tick();
        bus.d_data_ok = 1'b0;
        chk("mis_pulse", {31'd0, ld_misalign}, 32'd1);
        chk("mis_we", {31'd0, write_enable}, 32'd0);
        tick();
        chk("mis_pulse_drop", {31'd0, ld_misalign}, 32'd0);
`endif

        // ---- reset mid-load abandons the load
        present(1'b1, 5'd9, 1'b1, 3'd4, 2'd0, 32'h0, 32'h0000_0500);
        tick();
        bus.m_valid = 1'b0;
        tick();
        chk("midrst_busy_pre", {31'd0, fwd_busy}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, fwd_busy}, 32'd0);
        chk("midrst_ready", {31'd0, bus.m_ready}, 32'd1);
        chk("midrst_wb_pc", wb_pc, RESET_PC);
        tick();
        resetn        = 1'b1;
        bus.d_data_ok = 1'b1;
        bus.d_data    = 32'h5555_aaaa;
        tick();
        chk("midrst_we_a", {31'd0, write_enable}, 32'd0);
        tick();
        bus.d_data_ok = 1'b0;
        chk("midrst_we_b", {31'd0, write_enable}, 32'd0);
        chk("midrst_ready_post", {31'd0, bus.m_ready}, 32'd1);
        chk("midrst_wd3", wd3, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
